// File: rtl/rf_scoreboard_pkg.sv
// Shared widths for the register-file scoreboard; also carries the defs.v register-file macros
// so every scoreboard file sees one definition.
`ifndef LEN_INST_REG
`define LEN_INST_REG 5
`endif
`ifndef SIZE_RF
`define SIZE_RF 32
`endif
`ifndef LEN_DATA
`define LEN_DATA 32
`endif
`ifndef LEN_SB_CNT
`define LEN_SB_CNT 2
`endif

package rf_scoreboard_pkg;

  localparam int unsigned REG_W    = `LEN_INST_REG;
  localparam int unsigned NUM_REGS = `SIZE_RF;
  localparam int unsigned SB_CNT_W = `LEN_SB_CNT;

  typedef logic [REG_W-1:0] reg_idx_t;

  // One-hot decode of a register index with register 0 masked off.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx, input logic en);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (en && (idx != '0)) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One register's in-flight write counter: increment on accepted issue, decrement on writeback,
// saturation and underflow reporting.
module sb_entry
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_retire,
  output logic o_busy,
  output logic o_full,
  output logic o_pending_next,
  output logic o_underflow
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_dec;
  logic             w_inc;

  assign w_dec       = i_retire && (r_cnt != '0);
  // Guard against wrap; the top already stalls issue when full without a retire.
  assign w_inc       = i_inc && ((r_cnt != CntMax) || w_dec);
  assign o_underflow = i_retire && (r_cnt == '0);

  // The last pending write lands at this cycle's negedge, so it is already readable.
  assign o_busy = (r_cnt != '0) && !((r_cnt == CNT_W'(1)) && i_retire);
  assign o_full = (r_cnt == CntMax) && !i_retire;

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_inc && !w_dec) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end else if (!w_inc && w_dec) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  assign o_pending_next = (w_cnt_d != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Issue-side scoreboard for the register file: stalls reads of registers with pending writes
// and bounds the number of outstanding writes per register.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     issue_valid,
  input  logic     issue_we,
  input  reg_idx_t issue_rd,
  input  reg_idx_t rs,
  input  reg_idx_t rt,
  input  logic     use_rs,
  input  logic     use_rt,
  input  logic     wb_valid,
  input  reg_idx_t wb_rd,
  output logic     stall,
  output logic     issue_ack,
  output logic     idle,
  output logic     err
);

  logic [NUM_REGS-1:0] w_retire;
  logic [NUM_REGS-1:0] w_issue_sel;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_pending_next;
  logic [NUM_REGS-1:0] w_underflow;

  logic w_src_stall;
  logic w_sat_stall;
  logic r_idle;
  logic r_err;

  assign w_retire    = reg_onehot(wb_rd, wb_valid);
  assign w_issue_sel = reg_onehot(issue_rd, issue_we);
  assign w_inc       = w_issue_sel & {NUM_REGS{issue_ack}};

  // Register 0 is hard-wired not-busy and never counted.
  assign w_busy[0]         = 1'b0;
  assign w_full[0]         = 1'b0;
  assign w_pending_next[0] = 1'b0;
  assign w_underflow[0]    = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk            (clk),
      .rst            (rst),
      .i_inc          (w_inc[g]),
      .i_retire       (w_retire[g]),
      .o_busy         (w_busy[g]),
      .o_full         (w_full[g]),
      .o_pending_next (w_pending_next[g]),
      .o_underflow    (w_underflow[g])
    );
  end

  // Source checks apply regardless of issue_valid; ID qualifies stall with its own valid.
  assign w_src_stall = (use_rs && w_busy[rs]) || (use_rt && w_busy[rt]);
  assign w_sat_stall = issue_valid && issue_we && w_full[issue_rd];
  assign stall       = w_src_stall || w_sat_stall;
  assign issue_ack   = issue_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_idle <= ~|w_pending_next;
      if (|w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign idle = r_idle;
  assign err  = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     issue_valid;
  logic     issue_we;
  reg_idx_t issue_rd;
  reg_idx_t rs;
  reg_idx_t rt;
  logic     use_rs;
  logic     use_rt;
  logic     wb_valid;
  reg_idx_t wb_rd;
  logic     stall;
  logic     issue_ack;
  logic     idle;
  logic     err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .rs          (rs),
    .rt          (rt),
    .use_rs      (use_rs),
    .use_rt      (use_rt),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .stall       (stall),
    .issue_ack   (issue_ack),
    .idle        (idle),
    .err         (err)
  );

  task automatic clear_inputs();
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_rd    = '0;
    rs          = '0;
    rt          = '0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
  endtask

  // Advance past a posedge, then leave one time unit before new inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input reg_idx_t rd);
    clear_inputs();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = rd;
    #1;
    n_total++;
    if (issue_ack !== 1'b1) begin
      $display("FAIL issue_ack_r%0d: got=%b want=1", rd, issue_ack);
      n_bad++;
    end
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (idle !== 1'b1) begin $display("FAIL reset_idle: got=%b want=1", idle); n_bad++; end
    n_total++;
    if (err !== 1'b0) begin $display("FAIL reset_err: got=%b want=0", err); n_bad++; end
    n_total++;
    if (stall !== 1'b0) begin $display("FAIL reset_stall: got=%b want=0", stall); n_bad++; end
  endtask

  task automatic test_basic();
    do_issue(5'd5);
    n_total++;
    if (idle !== 1'b0) begin $display("FAIL basic_idle_busy: got=%b want=0", idle); n_bad++; end
    clear_inputs();
    issue_valid = 1'b1;
    use_rs      = 1'b1;
    rs          = 5'd5;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b1 || issue_ack !== 1'b0) begin
        $display("FAIL basic_raw_stall[%0d]: stall=%b ack=%b want stall=1 ack=0", i, stall,
                 issue_ack);
        n_bad++;
      end
      step();
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    n_total++;
    if (stall !== 1'b0 || issue_ack !== 1'b1) begin
      $display("FAIL basic_bypass: stall=%b ack=%b want stall=0 ack=1", stall, issue_ack);
      n_bad++;
    end
    step();
    clear_inputs();
    #1;
    n_total++;
    if (idle !== 1'b1) begin $display("FAIL basic_idle_after_wb: got=%b want=1", idle); n_bad++; end
  endtask

  task automatic test_r0();
    clear_inputs();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    use_rs      = 1'b1;
    use_rt      = 1'b1;
    wb_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b0 || issue_ack !== 1'b1) begin
        $display("FAIL r0_stall[%0d]: stall=%b ack=%b want stall=0 ack=1", i, stall, issue_ack);
        n_bad++;
      end
      step();
      n_total++;
      if (idle !== 1'b1 || err !== 1'b0) begin
        $display("FAIL r0_idle_err[%0d]: idle=%b err=%b want idle=1 err=0", i, idle, err);
        n_bad++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) do_issue(5'd7);
    clear_inputs();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = 5'd7;
    #1;
    n_total++;
    if (stall !== 1'b1) begin $display("FAIL sat_fourth_stall: got=%b want=1", stall); n_bad++; end
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    #1;
    n_total++;
    if (stall !== 1'b0 || issue_ack !== 1'b1) begin
      $display("FAIL sat_with_wb: stall=%b ack=%b want stall=0 ack=1", stall, issue_ack);
      n_bad++;
    end
    step();
    wb_valid = 1'b0;
    #1;
    n_total++;
    if (stall !== 1'b1) begin $display("FAIL sat_still_full: got=%b want=1", stall); n_bad++; end
    // Drain three writebacks while a reader of r7 waits.
    clear_inputs();
    use_rs   = 1'b1;
    rs       = 5'd7;
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (stall !== (i == 2 ? 1'b0 : 1'b1)) begin
        $display("FAIL sat_drain_stall[%0d]: got=%b want=%b", i, stall, (i == 2 ? 1'b0 : 1'b1));
        n_bad++;
      end
      step();
    end
    clear_inputs();
    #1;
    n_total++;
    if (idle !== 1'b1 || err !== 1'b0) begin
      $display("FAIL sat_drained: idle=%b err=%b want idle=1 err=0", idle, err);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    do_issue(5'd9);
    clear_inputs();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = 5'd9;
    wb_valid    = 1'b1;
    wb_rd       = 5'd9;
    #1;
    n_total++;
    if (issue_ack !== 1'b1) begin $display("FAIL b2b_ack: got=%b want=1", issue_ack); n_bad++; end
    step();
    clear_inputs();
    issue_valid = 1'b1;
    use_rt      = 1'b1;
    rt          = 5'd9;
    #1;
    n_total++;
    if (stall !== 1'b1) begin $display("FAIL b2b_reader_stall: got=%b want=1", stall); n_bad++; end
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    #1;
    n_total++;
    if (stall !== 1'b0) begin $display("FAIL b2b_final_bypass: got=%b want=0", stall); n_bad++; end
    step();
    clear_inputs();
    #1;
    n_total++;
    if (idle !== 1'b1) begin $display("FAIL b2b_idle: got=%b want=1", idle); n_bad++; end
  endtask

  task automatic test_underflow();
    clear_inputs();
    wb_valid = 1'b1;
    wb_rd    = 5'd12;
    #1;
    n_total++;
    if (err !== 1'b0) begin $display("FAIL uf_err_before: got=%b want=0", err); n_bad++; end
    step();
    clear_inputs();
    step();
    use_rs = 1'b1;
    rs     = 5'd12;
    #1;
    n_total++;
    if (err !== 1'b1 || idle !== 1'b1 || stall !== 1'b0) begin
      $display("FAIL uf_sticky: err=%b idle=%b stall=%b want err=1 idle=1 stall=0", err, idle,
               stall);
      n_bad++;
    end
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (err !== 1'b0) begin $display("FAIL uf_rst_clears: got=%b want=0", err); n_bad++; end
  endtask

  task automatic test_reset_mid();
    do_issue(5'd3);
    do_issue(5'd4);
    n_total++;
    if (idle !== 1'b0) begin $display("FAIL rstmid_pending: got=%b want=0", idle); n_bad++; end
    clear_inputs();
    rst         = 1'b1;
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = 5'd3;
    step();
    rst = 1'b0;
    clear_inputs();
    issue_valid = 1'b1;
    use_rs      = 1'b1;
    rs          = 5'd3;
    use_rt      = 1'b1;
    rt          = 5'd4;
    #1;
    n_total++;
    if (idle !== 1'b1 || stall !== 1'b0) begin
      $display("FAIL rstmid_cleared: idle=%b stall=%b want idle=1 stall=0", idle, stall);
      n_bad++;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_r0();
    test_saturation();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
